data_mem_ctrl: RTL and testbench

Parametrised data memory with a request/response handshake, sub-word load/store support, configurable read latency and error reporting for misaligned or out-of-range accesses. It replaces the single-cycle word-only data memory in the processor's MEM stage. The core issues one load or store per request and holds the response until the core accepts it, so stalls come from `req_ready`/`resp_valid` rather than fixed timing.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_align.sv | 67 ++++++
 rtl/data_mem_ctrl.sv | 122 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE   = 2'b00,
    HALF   = 2'b01,
    WORD   = 2'b10,
    DOUBLE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Number of byte-offset bits in a W-bit word.
  function automatic int unsigned ob_of(input int unsigned w);
    return $clog2(w / 8);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store lane enables/shift, load extraction/extension, size checks.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int unsigned W  = 32,
  localparam int unsigned OB = ob_of(W),
  localparam int unsigned NB = W / 8
) (
  input  size_e          size,
  input  logic [OB-1:0]  offset,
  input  logic           is_unsigned,
  input  logic [W-1:0]   store_data,
  input  logic [W-1:0]   raw_word,
  output logic [NB-1:0]  be,
  output logic [W-1:0]   wdata,
  output logic [W-1:0]   load_data,
  output logic           misaligned,
  output logic           illegal
);

  logic [OB+2:0] sh;
  logic [NB-1:0] mask;
  logic [W-1:0]  shifted;
  logic [W-1:0]  keep;
  logic          sgn;

  assign sh = {offset, 3'b000};

  always_comb begin
    mask       = '0;
    keep       = '1;
    sgn        = 1'b0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    shifted    = raw_word >> sh;
    case (size)
      BYTE: begin
        mask = NB'(1);
        keep = W'(8'hFF);
        sgn  = shifted[7];
      end
      HALF: begin
        mask       = NB'(3);
        keep       = W'(16'hFFFF);
        sgn        = shifted[15];
        misaligned = offset[0];
      end
      WORD: begin
        mask       = NB'(4'hF);
        keep       = W'(32'hFFFF_FFFF);
        sgn        = shifted[31];
        misaligned = |offset[1:0];
      end
      DOUBLE: begin
        mask       = '1;
        misaligned = |offset;
        illegal    = (W == 32);
      end
      default: ;
    endcase
    be        = mask << offset;
    wdata     = store_data << sh;
    // Bits above the access size take the sign bit unless zero-extending.
    load_data = (shifted & keep) | (~keep & {W{sgn & ~is_unsigned}});
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory with request/response handshake, sub-word access, read latency and error flagging.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned N         = 8,
  parameter int unsigned LAT       = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [W-1:0] address,
  input  logic [W-1:0] write_data,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] read_data,
  output logic         err
);

  localparam int unsigned OB       = ob_of(W);
  localparam int unsigned NB       = W / 8;
  localparam int unsigned DEPTH    = 2 ** N;
  localparam int unsigned CW       = (LAT > 2) ? $clog2(LAT - 1) : 1;
  localparam int unsigned CNT_INIT = (LAT > 1) ? LAT - 2 : 0;

  logic [W-1:0]  mem [DEPTH];
  state_e        state;
  logic [CW-1:0] cnt;

  logic [N-1:0]  idx;
  logic [OB-1:0] offset;
  logic          oor;
  logic          misaligned;
  logic          illegal;
  logic          bad;
  logic          accept;
  logic [NB-1:0] be;
  logic [W-1:0]  wdata;
  logic [W-1:0]  load_data;

  assign idx       = address[N+OB-1:OB];
  assign offset    = address[OB-1:0];
  assign oor       = |address[W-1:N+OB];
  assign bad       = oor | misaligned | illegal;
  assign req_ready = (state == IDLE);
  assign accept    = rst & req_valid & req_ready;

  dmem_lane_align #(.W(W)) u_align (
    .size        (size_e'(req_size)),
    .offset      (offset),
    .is_unsigned (req_unsigned),
    .store_data  (write_data),
    .raw_word    (mem[idx]),
    .be          (be),
    .wdata       (wdata),
    .load_data   (load_data),
    .misaligned  (misaligned),
    .illegal     (illegal)
  );

  // Lane-enabled store on the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && req_we && !bad) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      read_data  <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            err <= bad;
            if (bad || req_we) begin
              read_data  <= '0;
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              read_data <= load_data;
              if (LAT == 1) begin
                state      <= RESP;
                resp_valid <= 1'b1;
              end else begin
                state <= WAIT;
                cnt   <= CW'(CNT_INIT);
              end
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: three configurations (W32/LAT1, W32/LAT3, W64/LAT2) against a byte-array model.
module tb_data_mem_ctrl;

  localparam int WS   [3] = '{32, 32, 64};
  localparam int LATS [3] = '{1, 3, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic        rv [3];
  logic        we [3];
  logic        uns[3];
  logic        rr [3];
  logic [1:0]  sz [3];
  logic [63:0] ad [3];
  logic [63:0] wd [3];
  wire         rdy[3];
  wire         vld[3];
  wire         er [3];
  wire  [63:0] rd [3];
  wire  [31:0] rd0;
  wire  [31:0] rd1;
  wire  [63:0] rd2;

  assign rd[0] = {32'b0, rd0};
  assign rd[1] = {32'b0, rd1};
  assign rd[2] = rd2;

  always #5 clk = ~clk;

  data_mem_ctrl #(.W(32), .N(8), .LAT(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_size(sz[0]), .req_unsigned(uns[0]), .address(ad[0][31:0]), .write_data(wd[0][31:0]),
    .resp_valid(vld[0]), .resp_ready(rr[0]), .read_data(rd0), .err(er[0]));

  data_mem_ctrl #(.W(32), .N(8), .LAT(3)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_size(sz[1]), .req_unsigned(uns[1]), .address(ad[1][31:0]), .write_data(wd[1][31:0]),
    .resp_valid(vld[1]), .resp_ready(rr[1]), .read_data(rd1), .err(er[1]));

  data_mem_ctrl #(.W(64), .N(8), .LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rdy[2]), .req_we(we[2]),
    .req_size(sz[2]), .req_unsigned(uns[2]), .address(ad[2]), .write_data(wd[2]),
    .resp_valid(vld[2]), .resp_ready(rr[2]), .read_data(rd2), .err(er[2]));

  logic [7:0] mref [3][2048];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s (dut%0d): observed %h expected %h", tag, d, obs, exp);
    end
  endtask

  // Reference: little-endian byte array, error rules, and sign/zero extension.
  task automatic model(input int d, input logic w, input logic [1:0] s, input logic u,
                       input logic [63:0] a_in, input logic [63:0] wd_in,
                       output logic [63:0] exp_d, output logic exp_e);
    int nb = 1 << s;
    int wbytes = WS[d] / 8;
    logic [63:0] a = (WS[d] == 32) ? {32'b0, a_in[31:0]} : a_in;
    logic [63:0] v = '0;
    logic ill = (s == 2'b11) && (WS[d] == 32);
    logic mis = (a % 64'(nb)) != 0;
    logic oor = a >= 64'(wbytes * 256);
    exp_e = ill || mis || oor;
    exp_d = '0;
    if (!exp_e) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mref[d][int'(a) + i] = wd_in[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mref[d][int'(a) + i];
        if (!u && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        if (WS[d] == 32) v = {32'b0, v[31:0]};
        exp_d = v;
      end
    end
  endtask

  // One full transaction: issue, measure latency, optional back-pressure, handshake.
  task automatic xact(input int d, input logic w, input logic [1:0] s, input logic u,
                      input logic [63:0] a, input logic [63:0] wdat, input int hold,
                      output logic [63:0] got, output logic gerr);
    logic [63:0] exp_d;
    logic        exp_e;
    int          lat;
    model(d, w, s, u, a, wdat, exp_d, exp_e);
    chk("req_ready_idle", d, 64'(rdy[d]), 64'd1);
    rv[d] = 1'b1; we[d] = w; sz[d] = s; uns[d] = u; ad[d] = a; wd[d] = wdat;
    @(posedge clk);
    @(negedge clk);
    rv[d] = 1'b0; we[d] = ~w; sz[d] = 2'(~s); ad[d] = {$urandom, $urandom}; wd[d] = {$urandom, $urandom};
    lat = 1;
    while (!vld[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (w && !exp_e) chk("store_latency", d, 64'(lat), 64'd1);
    else if (!exp_e) chk("load_latency", d, 64'(lat), 64'(LATS[d]));
    else chk("err_resp_seen", d, 64'(vld[d]), 64'd1);
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid", d, 64'(vld[d]), 64'd1);
      chk("hold_ready_low", d, 64'(rdy[d]), 64'd0);
      chk("hold_data", d, rd[d], exp_d);
      @(negedge clk);
    end
    got  = rd[d];
    gerr = er[d];
    chk("read_data", d, rd[d], exp_d);
    chk("err", d, 64'(er[d]), 64'(exp_e));
    rr[d] = 1'b1;
    @(negedge clk);
    rr[d] = 1'b0;
    chk("idle_after_hs", d, {62'b0, vld[d], rdy[d]}, 64'b01);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    logic        gerr;
    logic [1:0]  s;
    logic [63:0] a;
    for (int d = 0; d < 3; d++) begin
      rv[d] = 0; we[d] = 0; uns[d] = 0; rr[d] = 0; sz[d] = 0; ad[d] = 0; wd[d] = 0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", d, 64'(rdy[d]), 64'd1);
      chk("rst_valid", d, 64'(vld[d]), 64'd0);
      chk("rst_err", d, 64'(er[d]), 64'd0);
      chk("rst_data", d, rd[d], 64'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Known contents for the low 64 bytes of every instance.
    for (int d = 0; d < 3; d++) begin
      for (int b = 0; b < 64; b += WS[d] / 8)
        xact(d, 1'b1, (WS[d] == 64) ? 2'b11 : 2'b10, 1'b0, 64'(b), {$urandom, $urandom}, 0, got, gerr);
    end

    xact(0, 1'b1, 2'b10, 1'b0, 64'h10, 64'hDEADBEEF, 0, got, gerr);
    xact(0, 1'b0, 2'b10, 1'b0, 64'h10, 64'h0, 0, got, gerr);
    chk("lw_deadbeef", 0, got, 64'hDEADBEEF);
    xact(0, 1'b0, 2'b00, 1'b0, 64'h13, 64'h0, 0, got, gerr);
    chk("lb_signed", 0, got, 64'hFFFFFFDE);
    xact(0, 1'b0, 2'b00, 1'b1, 64'h13, 64'h0, 0, got, gerr);
    chk("lbu", 0, got, 64'h000000DE);
    xact(0, 1'b0, 2'b01, 1'b0, 64'h12, 64'h0, 1, got, gerr);
    chk("lh_signed", 0, got, 64'hFFFFDEAD);
    xact(0, 1'b1, 2'b00, 1'b0, 64'h11, 64'h55, 0, got, gerr);
    xact(0, 1'b0, 2'b10, 1'b0, 64'h10, 64'h0, 0, got, gerr);
    chk("lw_after_sb", 0, got, 64'hDEAD55EF);
    xact(0, 1'b0, 2'b01, 1'b0, 64'h11, 64'h0, 0, got, gerr);
    chk("lh_misaligned_err", 0, {63'b0, gerr}, 64'd1);
    xact(0, 1'b1, 2'b10, 1'b0, 64'h02, 64'h12345678, 0, got, gerr);
    chk("sw_misaligned_err", 0, {63'b0, gerr}, 64'd1);
    xact(0, 1'b0, 2'b10, 1'b0, 64'h00, 64'h0, 0, got, gerr);
    xact(0, 1'b0, 2'b10, 1'b0, 64'h400, 64'h0, 0, got, gerr);
    chk("oor_err", 0, {63'b0, gerr}, 64'd1);
    xact(0, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 0, got, gerr);
    chk("size11_err", 0, {63'b0, gerr}, 64'd1);

    // Long latency with four cycles of back-pressure.
    xact(1, 1'b0, 2'b10, 1'b0, 64'h20, 64'h0, 4, got, gerr);

    // Reset while waiting drops the response; a store presented during reset is ignored.
    rv[1] = 1'b1; we[1] = 1'b0; sz[1] = 2'b10; ad[1] = 64'h20;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rv[1] = 1'b1; we[1] = 1'b1; wd[1] = 64'hBADC0FFE;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wait_ready", 1, 64'(rdy[1]), 64'd1);
    chk("rst_wait_valid", 1, 64'(vld[1]), 64'd0);
    chk("rst_wait_data", 1, rd[1], 64'd0);
    rst = 1'b1; rv[1] = 1'b0; we[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("no_resp_after_rst", 1, 64'(vld[1]), 64'd0);
      @(negedge clk);
    end
    xact(1, 1'b0, 2'b10, 1'b0, 64'h20, 64'h0, 0, got, gerr);

    xact(2, 1'b1, 2'b11, 1'b0, 64'h08, 64'h0123456789ABCDEF, 0, got, gerr);
    xact(2, 1'b0, 2'b10, 1'b0, 64'h0C, 64'h0, 0, got, gerr);
    chk("w64_lw_upper", 2, got, 64'h0000000001234567);

    for (int k = 0; k < 120; k++) begin
      int d = k % 3;
      s = 2'($urandom_range(0, 3));
      a = 64'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~64'((1 << s) - 1);
      if ($urandom_range(0, 7) == 0) a[8 + (WS[d] / 32) + 1 + $urandom_range(0, 3)] = 1'b1;
      xact(d, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a,
           {$urandom, $urandom}, int'($urandom_range(0, 2)), got, gerr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
